mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Single-port byte memory behind an IDLE/ACCESS/DONE sequencer with per-op latency,
// out-of-range detection and a one-cycle completion pulse qualified by MemError.
module mem_access_unit #(
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       MemRead,
  input  logic       MemWrite,
  input  logic [7:0] Address,
  input  logic [7:0] WriteData,
  output logic [7:0] ReadData,
  output logic       MemBusy,
  output logic       MemDone,
  output logic       MemError,
  output logic [1:0] dbg_state
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW   = 1 << AW;
  localparam int LMAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW   = $clog2(LMAX + 1);
  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  // Handshake: a request is taken only while dbg_state reads IDLE; MemDone is a
  // single-cycle pulse, MemError is valid only alongside it, MemBusy marks ACCESS.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            is_read_q, is_read_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [7:0]      mem_q [MW];
  logic            mem_we;
  logic            addr_oob;

  assign addr_oob = ({1'b0, addr_q} >= DEPTH_L);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (MemRead && MemWrite) begin
          // Conflicting request: report it without touching memory.
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (MemRead || MemWrite) begin
          addr_d    = Address;
          wdata_d   = WriteData;
          is_read_d = MemRead;
          cnt_d     = MemRead ? CW'(READ_LATENCY - 1) : CW'(WRITE_LATENCY - 1);
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_DONE;
          err_d   = addr_oob;
          if (is_read_q) begin
            rdata_d = addr_oob ? 8'h00 : mem_q[addr_q[AW-1:0]];
          end else begin
            mem_we = ~addr_oob;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      for (int i = 0; i < MW; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      if (mem_we) begin
        mem_q[addr_q[AW-1:0]] <= wdata_q;
      end
    end
  end

  assign ReadData  = rdata_q;
  assign MemBusy   = (state_q == S_ACCESS);
  assign MemDone   = (state_q == S_DONE);
  assign MemError  = (state_q == S_DONE) && err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised bench for mem_access_unit: a driver pushes expected completions from a
// byte-array reference model; a monitor pops and checks them when MemDone appears.
module tb_mem_access_unit;

  localparam int DEPTH = 128;
  localparam int RL    = 2;
  localparam int WL    = 1;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       MemRead, MemWrite;
  logic [7:0] Address, WriteData;
  logic [7:0] ReadData;
  logic       MemBusy, MemDone, MemError;
  logic [1:0] dbg_state;

  mem_access_unit #(
    .DEPTH         (DEPTH),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .MemBusy   (MemBusy),
    .MemDone   (MemDone),
    .MemError  (MemError),
    .dbg_state (dbg_state)
  );

  // clock / reset-free edge counter
  always #5 Clk = ~Clk;

  int edge_n = 0;
  always @(posedge Clk) edge_n <= edge_n + 1;

  int checks   = 0;
  int failures = 0;

  // entry: [41:10] edge after which MemDone shows, [9] is_read, [8] error, [7:0] read data
  logic [41:0] exp_q [$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  hold = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [41:0] e;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset) begin
        chk("reset_rdata", ReadData, 8'h00);
        chk("reset_busy",  MemBusy,  1'b0);
        chk("reset_done",  MemDone,  1'b0);
        chk("reset_err",   MemError, 1'b0);
        hold = 8'h00;
      end else begin
        if (exp_q.size() > 0 && int'(exp_q[0][41:10]) < edge_n) begin
          checks++;
          failures++;
          $display("FAIL missing_done actual=none required=edge_%0d", int'(exp_q[0][41:10]));
          void'(exp_q.pop_front());
        end
        if (MemDone) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 (edge %0d)", edge_n);
          end else begin
            e = exp_q.pop_front();
            chk("done_edge", edge_n, e[41:10]);
            chk("done_error", MemError, e[8]);
            if (e[9]) begin
              chk("read_data", ReadData, e[7:0]);
              hold = e[7:0];
            end else begin
              chk("data_hold", ReadData, hold);
            end
          end
        end else begin
          chk("err_without_done", MemError, 1'b0);
          chk("data_hold", ReadData, hold);
        end
      end
    end
  end

  // driver tasks
  task automatic scramble();
    MemRead   = 1'($urandom_range(0, 1));
    MemWrite  = 1'($urandom_range(0, 1));
    Address   = 8'($urandom_range(0, 255));
    WriteData = 8'($urandom_range(0, 255));
  endtask

  task automatic do_op(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] data);
    int   le;
    int   k;
    bit   err;
    logic [7:0] rv;
    @(negedge Clk);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = data;
    k   = edge_n + 1;
    err = (int'(addr) >= DEPTH);
    if (rd && wr) begin
      le = 0;
      exp_q.push_back({32'(k), 1'b0, 1'b1, 8'h00});
    end else if (rd) begin
      le = RL;
      rv = err ? 8'h00 : ref_mem[addr];
      exp_q.push_back({32'(k + le), 1'b1, err, rv});
    end else begin
      le = WL;
      if (!err) ref_mem[addr] = data;
      exp_q.push_back({32'(k + le), 1'b0, err, 8'h00});
    end
    @(posedge Clk);
    #1;
    chk("busy_after_accept", MemBusy, (le > 0));
    for (int i = 1; i <= le + 1; i++) begin
      @(negedge Clk);
      scramble();
      @(posedge Clk);
      #1;
      chk("busy", MemBusy, (i < le));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Address  = 8'($urandom_range(0, 255));
      @(posedge Clk);
    end
  endtask

  task automatic abort_op(input bit rd, input logic [7:0] addr, input logic [7:0] data);
    @(negedge Clk);
    MemRead   = rd;
    MemWrite  = ~rd;
    Address   = addr;
    WriteData = data;
    @(posedge Clk);
    @(negedge Clk);
    Reset    = 1'b1;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // main sequence
  initial begin
    int kind;
    logic [7:0] a;
    Reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 8'h00;
    WriteData = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    do_op(1'b0, 1'b1, 8'h10, 8'hA5);
    do_op(1'b1, 1'b0, 8'h10, 8'h00);
    idle(3);
    do_op(1'b1, 1'b1, 8'h10, 8'h77);
    do_op(1'b1, 1'b0, 8'h10, 8'h00);
    do_op(1'b0, 1'b1, 8'h80, 8'h3C);
    do_op(1'b1, 1'b0, 8'h80, 8'h00);
    do_op(1'b1, 1'b0, 8'h00, 8'h00);
    do_op(1'b0, 1'b1, 8'h7F, 8'hEE);
    do_op(1'b1, 1'b0, 8'h7F, 8'h00);
    do_op(1'b1, 1'b0, 8'hFF, 8'h00);
    do_op(1'b0, 1'b1, 8'h20, 8'h5A);
    abort_op(1'b0, 8'h20, 8'h99);
    do_op(1'b1, 1'b0, 8'h20, 8'h00);
    do_op(1'b1, 1'b0, 8'h10, 8'h00);
    do_op(1'b0, 1'b1, 8'h30, 8'h42);
    abort_op(1'b1, 8'h30, 8'h00);
    do_op(1'b1, 1'b0, 8'h30, 8'h00);

    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 9));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      if (kind == 0)      do_op(1'b1, 1'b1, a, 8'($urandom_range(0, 255)));
      else if (kind <= 4) do_op(1'b1, 1'b0, a, 8'($urandom_range(0, 255)));
      else if (kind <= 8) do_op(1'b0, 1'b1, a, 8'($urandom_range(0, 255)));
      else                idle(int'($urandom_range(1, 3)));
    end

    idle(6);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
